// File: rtl/unified_mem_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// unified_mem_arbiter_pkg
// Shared definitions for the unified memory arbiter:
//   - default SRAM-port widths (address, data, byte enables)
//   - FSM state encoding (IDLE, DATA, INST, RESP as 2-bit codes)
//   - position of the bus stall source in the core's stall-request vector
//   - helper decode: states in which the memory port is busy
// -----------------------------------------------------------------------------
package unified_mem_arbiter_pkg;

    localparam int UMA_ADDR_W = 32;
    localparam int UMA_DATA_W = 32;
    localparam int UMA_WEN_W  = UMA_DATA_W / 8;

    localparam logic [1:0] UMA_IDLE = 2'd0;
    localparam logic [1:0] UMA_DATA = 2'd1;
    localparam logic [1:0] UMA_INST = 2'd2;
    localparam logic [1:0] UMA_RESP = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = UMA_IDLE,
        ST_DATA = UMA_DATA,
        ST_INST = UMA_INST,
        ST_RESP = UMA_RESP
    } uma_state_t;

    // Bit of the core stall controller's request vector fed by stallreq_bus.
    localparam int UMA_STALL_BUS_BIT = 4;

    // The memory port is owned (and the core frozen) only in DATA and INST.
    function automatic logic uma_is_busy(input uma_state_t s);
        return (s == ST_DATA) || (s == ST_INST);
    endfunction

endpackage

// File: rtl/unified_mem_arbiter_fetch_buf.sv
// -----------------------------------------------------------------------------
// uma_fetch_buf
// One-entry instruction fetch buffer used when UMA_IFETCH_BUF_EN is defined.
// Holds the address/data of the most recent fetch that completed on memory.
// Ports:
//   i_clk, i_rst_n        clock, asynchronous active-low reset (clears valid)
//   i_lookup_en/addr      fetch being captured this cycle
//   i_inv_en/word         data write being captured this cycle (word address)
//   i_fill_en/addr/data   fetch completing on memory this cycle
//   o_hit, o_data         lookup hits the buffer; buffered instruction word
// -----------------------------------------------------------------------------
module uma_fetch_buf
    import unified_mem_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = UMA_ADDR_W,
    parameter int DATA_WIDTH = UMA_DATA_W
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_lookup_en,
    input  logic [ADDR_WIDTH-1:0]   i_lookup_addr,
    input  logic                    i_inv_en,
    input  logic [ADDR_WIDTH-3:0]   i_inv_word,
    input  logic                    i_fill_en,
    input  logic [ADDR_WIDTH-1:0]   i_fill_addr,
    input  logic [DATA_WIDTH-1:0]   i_fill_data,
    output logic                    o_hit,
    output logic [DATA_WIDTH-1:0]   o_data
);

    logic                  r_valid;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  w_inv_match;

    // A write captured together with a fetch to the same word must win: the
    // hit is suppressed so the fetch is sent to memory after the write lands.
    assign w_inv_match = i_inv_en && (i_inv_word == r_addr[ADDR_WIDTH-1:2]);
    assign o_hit       = i_lookup_en && r_valid && (i_lookup_addr == r_addr) && !w_inv_match;
    assign o_data      = r_data;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_valid <= 1'b0;
            r_addr  <= '0;
            r_data  <= '0;
        end else if (i_fill_en) begin
            r_valid <= 1'b1;
            r_addr  <= i_fill_addr;
            r_data  <= i_fill_data;
        end else if (w_inv_match) begin
            r_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/unified_mem_arbiter.sv
// -----------------------------------------------------------------------------
// unified_mem_arbiter
// Merges the core's instruction-SRAM and data-SRAM ports onto one shared,
// variable-latency, single-outstanding memory port. A data access captured
// together with a fetch is issued first. stallreq_bus freezes the pipeline
// while captured accesses are on the memory port; read data is registered
// and held until the next completion of the same kind.
//
// Build option: UMA_IFETCH_BUF_EN adds a one-entry fetch buffer
// (uma_fetch_buf) that serves repeated fetches without a memory access.
//
// Ports:
//   clk, rst                      clock; asynchronous active-low reset
//   inst_sram_*                   core fetch port (wen/wdata unused)
//   data_sram_*                   core load/store port (wen==0 is a read)
//   stallreq_bus                  pipeline stall request (state decode only)
//   mem_req/wen/addr/wdata        shared memory request
//   mem_ack/rdata                 shared memory completion
//   o_dbg_state                   current FSM state
//
// Memory handshake: mem_req is high exactly while an access is in flight and
// mem_wen/addr/wdata are stable for that whole time; the access completes on
// the first rising edge where mem_ack is high (read data valid in that same
// cycle). mem_ack while mem_req is low has no effect.
// -----------------------------------------------------------------------------
module unified_mem_arbiter
    import unified_mem_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = UMA_ADDR_W,
    parameter int DATA_WIDTH = UMA_DATA_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    inst_sram_en,
    input  logic [DATA_WIDTH/8-1:0] inst_sram_wen,
    input  logic [ADDR_WIDTH-1:0]   inst_sram_addr,
    input  logic [DATA_WIDTH-1:0]   inst_sram_wdata,
    output logic [DATA_WIDTH-1:0]   inst_sram_rdata,
    input  logic                    data_sram_en,
    input  logic [DATA_WIDTH/8-1:0] data_sram_wen,
    input  logic [ADDR_WIDTH-1:0]   data_sram_addr,
    input  logic [DATA_WIDTH-1:0]   data_sram_wdata,
    output logic [DATA_WIDTH-1:0]   data_sram_rdata,
    output logic                    stallreq_bus,
    output logic                    mem_req,
    output logic [DATA_WIDTH/8-1:0] mem_wen,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    input  logic                    mem_ack,
    input  logic [DATA_WIDTH-1:0]   mem_rdata,
    output logic [1:0]              o_dbg_state
);

    localparam int WEN_W = DATA_WIDTH / 8;

    uma_state_t            r_state;
    uma_state_t            w_state_nxt;

    logic [WEN_W-1:0]      r_d_wen;
    logic [ADDR_WIDTH-1:0] r_d_addr;
    logic [DATA_WIDTH-1:0] r_d_wdata;
    logic [ADDR_WIDTH-1:0] r_i_addr;
    logic                  r_inst_pend;
    logic [DATA_WIDTH-1:0] r_inst_rdata;
    logic [DATA_WIDTH-1:0] r_data_rdata;

    logic                  w_busy;
    logic                  w_capture;
    logic                  w_cap_data;
    logic                  w_cap_inst;
    logic                  w_fetch_mem;
    logic                  w_data_done;
    logic                  w_inst_done;
    logic                  w_buf_hit;
    logic [DATA_WIDTH-1:0] w_buf_data;
    logic                  w_unused_inst_wr;

    // Fetch port is read-only; its write-side inputs exist for symmetry.
    assign w_unused_inst_wr = ^{inst_sram_wen, inst_sram_wdata};

    assign w_busy      = uma_is_busy(r_state);
    assign w_capture   = (r_state == ST_IDLE) || (r_state == ST_RESP);
    assign w_cap_data  = w_capture && data_sram_en;
    assign w_cap_inst  = w_capture && inst_sram_en;
    assign w_fetch_mem = w_cap_inst && !w_buf_hit;
    assign w_data_done = (r_state == ST_DATA) && mem_ack;
    assign w_inst_done = (r_state == ST_INST) && mem_ack;

`ifdef UMA_IFETCH_BUF_EN
    logic w_data_wr_cap;
    assign w_data_wr_cap = w_cap_data && (data_sram_wen != '0);

    uma_fetch_buf #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_fetch_buf (
        .i_clk         (clk),
        .i_rst_n       (rst),
        .i_lookup_en   (w_cap_inst),
        .i_lookup_addr (inst_sram_addr),
        .i_inv_en      (w_data_wr_cap),
        .i_inv_word    (data_sram_addr[ADDR_WIDTH-1:2]),
        .i_fill_en     (w_inst_done),
        .i_fill_addr   (r_i_addr),
        .i_fill_data   (mem_rdata),
        .o_hit         (w_buf_hit),
        .o_data        (w_buf_data)
    );
`else
    assign w_buf_hit  = 1'b0;
    assign w_buf_data = '0;
`endif

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE, ST_RESP: begin
                if (data_sram_en) begin
                    w_state_nxt = ST_DATA;
                end else if (inst_sram_en) begin
                    // A buffered fetch completes at capture, without a stall.
                    w_state_nxt = w_buf_hit ? ST_RESP : ST_INST;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_DATA: begin
                if (mem_ack) begin
                    w_state_nxt = r_inst_pend ? ST_INST : ST_RESP;
                end
            end
            ST_INST: begin
                if (mem_ack) begin
                    w_state_nxt = ST_RESP;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // ---------------- Capture and response registers ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_d_wen      <= '0;
            r_d_addr     <= '0;
            r_d_wdata    <= '0;
            r_i_addr     <= '0;
            r_inst_pend  <= 1'b0;
            r_inst_rdata <= '0;
            r_data_rdata <= '0;
        end else begin
            if (w_cap_data) begin
                r_d_wen     <= data_sram_wen;
                r_d_addr    <= data_sram_addr;
                r_d_wdata   <= data_sram_wdata;
                r_inst_pend <= inst_sram_en && !w_buf_hit;
            end
            if (w_fetch_mem) begin
                r_i_addr <= inst_sram_addr;
            end
            if (w_cap_inst && w_buf_hit) begin
                r_inst_rdata <= w_buf_data;
            end else if (w_inst_done) begin
                r_inst_rdata <= mem_rdata;
            end
            if (w_data_done && (r_d_wen == '0)) begin
                r_data_rdata <= mem_rdata;
            end
        end
    end

    // ---------------- Outputs ----------------
    assign mem_req         = w_busy;
    assign stallreq_bus    = w_busy;
    assign inst_sram_rdata = r_inst_rdata;
    assign data_sram_rdata = r_data_rdata;
    assign o_dbg_state     = r_state;

    always_comb begin
        mem_wen   = '0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (r_state == ST_DATA) begin
            mem_wen   = r_d_wen;
            mem_addr  = r_d_addr;
            mem_wdata = r_d_wdata;
        end else if (r_state == ST_INST) begin
            mem_addr  = r_i_addr;
        end
    end

endmodule
